button_conditioner: RTL and testbench

Conditions one raw push-button (a board KEY) into clean, single-cycle event pulses for the project-info display path. It synchronises the asynchronous pad into `i_clock` and debounces it. It then emits one press pulse, one release pulse, and an auto-repeat `o_change` stream while the button is held. `o_change` drives the `i_change` input of the info viewer directly, so one physical press advances the viewer exactly one page.

---
 rtl/button_conditioner_pkg.sv | 16 +
 rtl/debounce_filter.sv | 48 ++++
 rtl/button_conditioner.sv | 107 ++++++++++
 tb/tb_button_conditioner.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared types and sizing helper for the push-button conditioner.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    HOLD   = 2'd3
  } btn_state_t;

  // Bits needed to count 0 .. max_val-1, never fewer than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Polarity normalise, 2-flop synchronise and debounce one raw pad.
// o_accept is high in the cycle before o_stable flips.
module debounce_filter
  import button_conditioner_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 50_000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_stable,
  output logic o_accept
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            pressed;
  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] db_cnt;

  assign pressed  = i_raw ^ (ACTIVE_LOW != 0);
  // Lets the top register its pulses on the same edge that moves o_stable.
  assign o_accept = (sync2 != o_stable) && (db_cnt == DB_LAST);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      o_stable <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1 <= pressed;
      sync2 <= sync1;
      if (sync2 == o_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        o_stable <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounced button with press/release pulses and an auto-repeat change stream.
// All outputs are flops; release beats a coincident repeat.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int ACTIVE_LOW           = 1,
  parameter int DEBOUNCE_CYCLES      = 50_000,
  parameter int REPEAT_DELAY_CYCLES  = 25_000_000,
  parameter int REPEAT_PERIOD_CYCLES = 10_000_000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_button,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_change
);

  localparam int RP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                          REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RP_W   = cnt_width(RP_MAX);
  localparam logic [RP_W-1:0] DLY_LAST =
    RP_W'((REPEAT_DELAY_CYCLES > 0) ? REPEAT_DELAY_CYCLES - 1 : 0);
  localparam logic [RP_W-1:0] PER_LAST =
    RP_W'((REPEAT_PERIOD_CYCLES > 0) ? REPEAT_PERIOD_CYCLES - 1 : 0);

  btn_state_t      state, state_n;
  logic [RP_W-1:0] rp_cnt, rp_cnt_n;
  logic            press_n, release_n, change_n;
  logic            accept, rise, fall;

  debounce_filter #(
    .ACTIVE_LOW      (ACTIVE_LOW),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_filter (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_raw    (i_button),
    .o_stable (o_level),
    .o_accept (accept)
  );

  assign rise = accept & ~o_level;
  assign fall = accept &  o_level;

  always_comb begin
    state_n   = state;
    rp_cnt_n  = rp_cnt;
    press_n   = 1'b0;
    release_n = 1'b0;
    change_n  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          press_n  = 1'b1;
          change_n = 1'b1;
          rp_cnt_n = '0;
          state_n  = (REPEAT_DELAY_CYCLES == 0) ? HOLD : DELAY;
        end
      end
      DELAY: begin
        if (rp_cnt == DLY_LAST) begin
          change_n = 1'b1;
          rp_cnt_n = '0;
          state_n  = REPEAT;
        end else begin
          rp_cnt_n = rp_cnt + RP_W'(1);
        end
      end
      REPEAT: begin
        if (rp_cnt == PER_LAST) begin
          change_n = 1'b1;
          rp_cnt_n = '0;
        end else begin
          rp_cnt_n = rp_cnt + RP_W'(1);
        end
      end
      HOLD: ;
      default: state_n = IDLE;
    endcase
    // Applied last so a release overrides any repeat decided above.
    if (state != IDLE && fall) begin
      release_n = 1'b1;
      change_n  = 1'b0;
      rp_cnt_n  = '0;
      state_n   = IDLE;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      rp_cnt    <= '0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_change  <= 1'b0;
    end else begin
      state     <= state_n;
      rp_cnt    <= rp_cnt_n;
      o_press   <= press_n;
      o_release <= release_n;
      o_change  <= change_n;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: DEBOUNCE=4, DELAY=10, PERIOD=5 (dut) and DELAY=0 (dut2).
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic btn, btn2;
  logic lvl, prs, rls, chg;
  logic lvl2, prs2, rls2, chg2;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int press_n = 0, rel_n = 0, chg_n = 0, press_cyc = 0, rel_cyc = 0;
  int press2_n = 0, rel2_n = 0, chg2_n = 0, press2_cyc = 0;
  int both_n = 0;
  int chg_q[$];

  always #5 clk = ~clk;

  button_conditioner #(
    .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY_CYCLES(10), .REPEAT_PERIOD_CYCLES(5)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_button(btn),
    .o_level(lvl), .o_press(prs), .o_release(rls), .o_change(chg)
  );

  button_conditioner #(
    .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY_CYCLES(0), .REPEAT_PERIOD_CYCLES(5)
  ) dut2 (
    .i_clock(clk), .i_reset(rst), .i_button(btn2),
    .o_level(lvl2), .o_press(prs2), .o_release(rls2), .o_change(chg2)
  );

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (prs === 1'b1) begin press_n++; press_cyc = cyc; end
    if (rls === 1'b1) begin rel_n++; rel_cyc = cyc; end
    if (chg === 1'b1) begin chg_n++; chg_q.push_back(cyc); end
    if (prs2 === 1'b1) begin press2_n++; press2_cyc = cyc; end
    if (rls2 === 1'b1) rel2_n++;
    if (chg2 === 1'b1) chg2_n++;
    if (prs === 1'b1 && rls === 1'b1) both_n++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic act;
    rst = 1'b0; btn = 1'b1; btn2 = 1'b1;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({lvl, prs, rls, chg} !== 4'b0) begin
      n_fail++; $display("FAIL reset_async: got %b expected 0000", {lvl, prs, rls, chg});
    end
    step(3);
    n_checks++;
    if ({lvl, prs, rls, chg, lvl2, prs2, rls2, chg2} !== 8'b0) begin
      n_fail++; $display("FAIL reset_held: got %b expected 00000000",
                         {lvl, prs, rls, chg, lvl2, prs2, rls2, chg2});
    end
    rst = 1'b0;
    act = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      act = act | lvl | prs | rls | chg | lvl2 | prs2 | rls2 | chg2;
    end
    n_checks++;
    if (act !== 1'b0) begin
      n_fail++; $display("FAIL reset_quiet: got %b expected 0", act);
    end
  endtask

  task automatic test_clean_press();
    int e, p0, c0, r0;
    p0 = press_n; c0 = chg_n; r0 = rel_n;
    e = cyc; btn = 1'b0;
    step(5);
    n_checks++;
    if (lvl !== 1'b0) begin
      n_fail++; $display("FAIL press_early: got %b expected 0", lvl);
    end
    step(1);
    n_checks++;
    if ({lvl, prs, chg, rls} !== 4'b1110) begin
      n_fail++; $display("FAIL press_edge: got %b expected 1110", {lvl, prs, chg, rls});
    end
    step(2);
    btn = 1'b1;
    step(5);
    n_checks++;
    if (lvl !== 1'b1) begin
      n_fail++; $display("FAIL release_early: got %b expected 1", lvl);
    end
    step(1);
    n_checks++;
    if ({lvl, rls, prs, chg} !== 4'b0100) begin
      n_fail++; $display("FAIL release_edge: got %b expected 0100", {lvl, rls, prs, chg});
    end
    step(15);
    n_checks++;
    if ((press_n - p0) !== 1 || (chg_n - c0) !== 1 || (rel_n - r0) !== 1) begin
      n_fail++; $display("FAIL clean_counts: got p%0d c%0d r%0d expected p1 c1 r1",
                         press_n - p0, chg_n - c0, rel_n - r0);
    end
    n_checks++;
    if (press_cyc !== e + 6) begin
      n_fail++; $display("FAIL clean_latency: got %0d expected %0d", press_cyc, e + 6);
    end
  endtask

  task automatic test_bounce();
    int e, p0, c0, r0;
    p0 = press_n; c0 = chg_n; r0 = rel_n;
    for (int i = 0; i < 10; i++) begin
      btn = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(2);
    end
    n_checks++;
    if (press_n !== p0 || chg_n !== c0 || rel_n !== r0 || lvl !== 1'b0) begin
      n_fail++; $display("FAIL bounce_quiet: got p%0d c%0d r%0d l%b expected no activity",
                         press_n - p0, chg_n - c0, rel_n - r0, lvl);
    end
    e = cyc; btn = 1'b0;
    step(5);
    n_checks++;
    if (prs !== 1'b0) begin
      n_fail++; $display("FAIL bounce_early: got %b expected 0", prs);
    end
    step(1);
    n_checks++;
    if ({prs, chg, lvl} !== 3'b111) begin
      n_fail++; $display("FAIL bounce_press: got %b expected 111", {prs, chg, lvl});
    end
    btn = 1'b1;
    step(20);
    n_checks++;
    if ((press_n - p0) !== 1 || (chg_n - c0) !== 1 || (rel_n - r0) !== 1 || press_cyc !== e + 6) begin
      n_fail++; $display("FAIL bounce_counts: got p%0d c%0d r%0d at %0d expected p1 c1 r1 at %0d",
                         press_n - p0, chg_n - c0, rel_n - r0, press_cyc, e + 6);
    end
  endtask

  task automatic test_auto_repeat();
    int e, t0, base, p0, r0;
    int offs[8] = '{0, 10, 15, 20, 25, 30, 35, 40};
    p0 = press_n; r0 = rel_n; base = chg_q.size();
    e = cyc; t0 = e + 6; btn = 1'b0;
    step(42);
    btn = 1'b1;
    step(20);
    n_checks++;
    if (chg_q.size() - base !== 8) begin
      n_fail++; $display("FAIL repeat_count: got %0d expected 8", chg_q.size() - base);
    end
    for (int k = 0; k < 8; k++) begin
      if (base + k < chg_q.size()) begin
        n_checks++;
        if (chg_q[base + k] !== t0 + offs[k]) begin
          n_fail++; $display("FAIL repeat_time[%0d]: got %0d expected %0d",
                             k, chg_q[base + k], t0 + offs[k]);
        end
      end
    end
    n_checks++;
    if ((press_n - p0) !== 1 || press_cyc !== t0) begin
      n_fail++; $display("FAIL repeat_press: got %0d at %0d expected 1 at %0d",
                         press_n - p0, press_cyc, t0);
    end
    n_checks++;
    if ((rel_n - r0) !== 1 || rel_cyc !== t0 + 42) begin
      n_fail++; $display("FAIL repeat_release: got %0d at %0d expected 1 at %0d",
                         rel_n - r0, rel_cyc, t0 + 42);
    end
  endtask

  task automatic test_collision();
    int e, t0, base, c1;
    base = chg_q.size();
    e = cyc; t0 = e + 6; btn = 1'b0;
    step(40);
    btn = 1'b1;
    step(6);
    n_checks++;
    if ({rls, chg, lvl} !== 3'b100) begin
      n_fail++; $display("FAIL collision_edge: got %b expected 100", {rls, chg, lvl});
    end
    step(20);
    n_checks++;
    if (chg_q.size() - base !== 7 || rel_cyc !== t0 + 40) begin
      n_fail++; $display("FAIL collision_counts: got %0d changes, release at %0d expected 7, %0d",
                         chg_q.size() - base, rel_cyc, t0 + 40);
    end
    c1 = chg_n;
    e = cyc; btn = 1'b0;
    step(6);
    n_checks++;
    if ({prs, chg} !== 2'b11 || chg_n !== c1 + 1) begin
      n_fail++; $display("FAIL collision_idle: got %b/%0d expected 11/1", {prs, chg}, chg_n - c1);
    end
    btn = 1'b1;
    step(20);
  endtask

  task automatic test_reset_mid_hold();
    int r, p0;
    btn = 1'b0;
    step(20);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({lvl, prs, rls, chg} !== 4'b0) begin
      n_fail++; $display("FAIL midreset_async: got %b expected 0000", {lvl, prs, rls, chg});
    end
    step(2);
    p0 = press_n;
    rst = 1'b0; r = cyc;
    step(5);
    n_checks++;
    if (lvl !== 1'b0) begin
      n_fail++; $display("FAIL midreset_early: got %b expected 0", lvl);
    end
    step(1);
    n_checks++;
    if ({prs, lvl} !== 2'b11 || press_n !== p0 + 1 || press_cyc !== r + 6) begin
      n_fail++; $display("FAIL midreset_press: got %b at %0d expected 11 at %0d",
                         {prs, lvl}, press_cyc, r + 6);
    end
    btn = 1'b1;
    step(20);
  endtask

  task automatic test_repeat_disabled();
    int e, p0, c0, r0;
    p0 = press2_n; c0 = chg2_n; r0 = rel2_n;
    e = cyc; btn2 = 1'b0;
    step(100);
    btn2 = 1'b1;
    step(20);
    n_checks++;
    if ((press2_n - p0) !== 1 || (chg2_n - c0) !== 1 || (rel2_n - r0) !== 1) begin
      n_fail++; $display("FAIL norepeat_counts: got p%0d c%0d r%0d expected p1 c1 r1",
                         press2_n - p0, chg2_n - c0, rel2_n - r0);
    end
    n_checks++;
    if (press2_cyc !== e + 6) begin
      n_fail++; $display("FAIL norepeat_latency: got %0d expected %0d", press2_cyc, e + 6);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_collision();
    test_reset_mid_hold();
    test_repeat_disabled();
    n_checks++;
    if (both_n !== 0) begin
      n_fail++; $display("FAIL press_release_overlap: got %0d expected 0", both_n);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
